// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_sum;
    logic             bit_carry;
    logic             load;
    logic             step;
    logic             last;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    assign last = (cnt == LAST);
    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Visible sum/cout change only on the final bit, never mid-addition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= bit_carry;
            res   <= {bit_sum, res[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {bit_sum, res[WIDTH-1:1]};
                cout <= bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a result scoreboard.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int nb;
    int dc;
    int s;
    int d0;
    int dcs[3];

    logic [W:0]   exp_q[$];
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each done pulse; results must hold while busy.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst_n) begin
            held_sum  = '0;
            held_cout = 1'b0;
        end else if (done) begin
            done_cnt++;
            chk("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
                held_sum  = e[W-1:0];
                held_cout = e[W];
            end
        end else if (busy) begin
            chk("sum_hold", 32'(sum), 32'(held_sum));
            chk("cout_hold", 32'(cout), 32'(held_cout));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        exp_q.push_back((W+1)'(x) + (W+1)'(y) + (W+1)'(c));
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit push);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        if (push) push_exp(x, y, c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output int dcyc);
        nbusy = 0;
        dcyc  = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                dcyc = cyc;
                break;
            end
            if (busy) nbusy++;
        end
        chk("done_timeout", 32'(dcyc != -1), 1);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);

        rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_sum", 32'(sum), 0);
        chk("idle_cout", 32'(cout), 0);

        launch(8'hFF, 8'h01, 1'b0, 1'b1);
        s = cyc;
        wait_done(nb, dc);
        chk("ripple_busy_cycles", 32'(nb), 8);
        chk("ripple_latency", 32'(dc - s), 8);
        tick();
        chk("done_width", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);

        launch(8'hA5, 8'h5A, 1'b1, 1'b1);
        wait_done(nb, dc);
        tick();
        launch(8'h12, 8'h34, 1'b0, 1'b1);
        wait_done(nb, dc);
        tick();
        chk("sum_12_34", 32'(sum), 32'h46);
        chk("queue_drained", 32'(exp_q.size()), 0);

        d0 = done_cnt;
        launch(8'h0F, 8'h01, 1'b0, 1'b1);
        repeat (3) tick();
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done(nb, dc);
        repeat (4) tick();
        chk("single_done", 32'(done_cnt - d0), 1);
        chk("no_second_op", 32'(busy), 0);
        chk("immune_sum", 32'(sum), 32'h10);

        launch(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (4) tick();
        chk("abort_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_busy", 32'(busy), 0);
        chk("abort_rst_sum", 32'(sum), 0);
        chk("abort_rst_cout", 32'(cout), 0);
        tick();
        rst_n = 1'b1;
        d0    = done_cnt;
        repeat (12) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_cout", 32'(cout), 0);
        launch(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done(nb, dc);
        tick();
        chk("post_abort_sum", 32'(sum), 32'h03);

        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = 1'b1;
        push_exp(a, b, cin);
        for (int i = 0; i < 3; i++) begin
            wait_done(nb, dcs[i]);
            if (i < 2) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                push_exp(a, b, cin);
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b_gap01", 32'(dcs[1] - dcs[0]), 10);
        chk("b2b_gap12", 32'(dcs[2] - dcs[1]), 10);
        repeat (3) tick();
        chk("b2b_drained", 32'(exp_q.size()), 0);
        chk("b2b_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
